// File: rtl/key_event_ctrl.sv
// key_event_ctrl: debounced three-key command controller (open/close toggle, play/pause toggle, clear)
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous active-high reset
//   in_op_cl     raw hit level, open/close key region
//   in_pl_pa     raw hit level, play/pause key region
//   in_clear     raw hit level, clear key region
//   open_state   registered open/close toggle state (1 = open)
//   play_state   registered play/pause toggle state (1 = play)
//   clear_pulse  one-cycle clear command
//   key_event    one-cycle pulse on any accepted command
//   busy         high whenever the FSM is not in IDLE
//
// Build option: define CLEAR_LONGPRESS_EN to make the clear key act only after
// a long hold of HOLD_CYCLES cycles instead of at debounce completion.
module key_event_ctrl #(
    parameter logic [15:0] DEB_CYCLES  = 16'd50000,
    parameter logic [25:0] HOLD_CYCLES = 26'd50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic in_op_cl,
    input  logic in_pl_pa,
    input  logic in_clear,
    output logic open_state,
    output logic play_state,
    output logic clear_pulse,
    output logic key_event,
    output logic busy
);
    typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} state_t;
    typedef enum logic [1:0] {K_NONE, K_OP, K_PL, K_CL} key_t;

    localparam logic [15:0] DEB_MAX = DEB_CYCLES - 16'd1;

    if (DEB_CYCLES < 16'd2 || HOLD_CYCLES < 26'd2) begin : g_bad_param
        $error("key_event_ctrl: DEB_CYCLES and HOLD_CYCLES must be at least 2");
    end

    state_t      state;
    key_t        cand;
    key_t        hit_key;
    logic [15:0] cnt;
    logic [15:0] cnt_inc;
    logic [2:0]  hits;
    logic [2:0]  cand_mask;
    logic        cand_hi;
    logic        other_hi;

    assign hits = {in_clear, in_pl_pa, in_op_cl};

    // hit_key is K_NONE unless exactly one key region is hit
    always_comb begin
        hit_key   = hits == 3'b001 ? K_OP : hits == 3'b010 ? K_PL : hits == 3'b100 ? K_CL : K_NONE;
        cand_mask = cand == K_OP ? 3'b001 : cand == K_PL ? 3'b010 : cand == K_CL ? 3'b100 : 3'b000;
        cand_hi   = |(hits & cand_mask);
        other_hi  = |(hits & ~cand_mask);
        cnt_inc   = cnt == 16'hFFFF ? cnt : cnt + 16'd1;
    end

`ifdef CLEAR_LONGPRESS_EN
    localparam logic [25:0] HOLD_MAX = HOLD_CYCLES - 26'd1;
    logic [25:0] hold_cnt;
    logic [25:0] hold_inc;
    assign hold_inc = hold_cnt == 26'h3FFFFFF ? hold_cnt : hold_cnt + 26'd1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cand        <= K_NONE;
            cnt         <= '0;
            open_state  <= 1'b0;
            play_state  <= 1'b0;
            clear_pulse <= 1'b0;
            key_event   <= 1'b0;
            busy        <= 1'b0;
`ifdef CLEAR_LONGPRESS_EN
            hold_cnt    <= '0;
`endif
        end else begin
            clear_pulse <= 1'b0;
            key_event   <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit_key != K_NONE) begin
                        cand  <= hit_key;
                        cnt   <= '0;
                        state <= DEB_PRESS;
                        busy  <= 1'b1;
                    end
                end
                DEB_PRESS: begin
                    if (!cand_hi || other_hi) begin
                        state <= IDLE;
                        cand  <= K_NONE;
                        busy  <= 1'b0;
                    end else if (cnt == DEB_MAX) begin
                        state      <= HELD;
                        open_state <= open_state ^ (cand == K_OP);
                        play_state <= play_state ^ (cand == K_PL);
`ifdef CLEAR_LONGPRESS_EN
                        key_event  <= cand != K_CL;
                        // the entry cycle already counts as one held cycle
                        hold_cnt   <= 26'd1;
`else
                        clear_pulse <= cand == K_CL;
                        key_event   <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                HELD: begin
                    if (!cand_hi) begin
                        cnt   <= '0;
                        state <= DEB_REL;
                    end
`ifdef CLEAR_LONGPRESS_EN
                    else begin
                        // hold_cnt is not reset on a bounce back from DEB_REL,
                        // so a single press can never clear twice
                        hold_cnt <= hold_inc;
                        if (cand == K_CL && hold_cnt == HOLD_MAX) begin
                            clear_pulse <= 1'b1;
                            key_event   <= 1'b1;
                        end
                    end
`endif
                end
                DEB_REL: begin
                    if (cand_hi) begin
                        state <= HELD;
                    end else if (other_hi) begin
                        cnt <= '0;
                    end else if (cnt == DEB_MAX) begin
                        state <= IDLE;
                        cand  <= K_NONE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_key_event_ctrl.sv
// tb_key_event_ctrl: scoreboard bench for key_event_ctrl with DEB_CYCLES=4, HOLD_CYCLES=10
module tb_key_event_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_op_cl = 1'b0;
    logic in_pl_pa = 1'b0;
    logic in_clear = 1'b0;
    logic open_state, play_state, clear_pulse, key_event, busy;

    int checks = 0;
    int failures = 0;
    int pe = 0;
    bit mon_en = 1'b0;
    logic exp_open = 1'b0;
    logic exp_play = 1'b0;

    typedef struct {
        int   cyc;
        logic op;
        logic pl;
        logic clr;
    } ev_t;
    ev_t exp_q[$];

    key_event_ctrl #(.DEB_CYCLES(16'd4), .HOLD_CYCLES(26'd10)) dut (
        .clk(clk),
        .reset(reset),
        .in_op_cl(in_op_cl),
        .in_pl_pa(in_pl_pa),
        .in_clear(in_clear),
        .open_state(open_state),
        .play_state(play_state),
        .clear_pulse(clear_pulse),
        .key_event(key_event),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pe <= pe + 1;

    // scoreboard: every key_event pops one expected command and is matched against it
    logic prev_ke = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < pe) begin
                checks++;
                failures++;
                $display("FAIL missed_event: expected at edge %0d, still pending at edge %0d", exp_q[0].cyc, pe);
                void'(exp_q.pop_front());
            end
            if (key_event === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event: key_event at edge %0d open=%b play=%b clr=%b", pe, open_state, play_state, clear_pulse);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (pe !== e.cyc || open_state !== e.op || play_state !== e.pl || clear_pulse !== e.clr) begin
                        failures++;
                        $display("FAIL event_match: got edge=%0d open=%b play=%b clr=%b, want edge=%0d open=%b play=%b clr=%b",
                                 pe, open_state, play_state, clear_pulse, e.cyc, e.op, e.pl, e.clr);
                    end
                end
                if (prev_ke === 1'b1) begin
                    checks++;
                    failures++;
                    $display("FAIL consecutive_event: key_event high two cycles at edge %0d", pe);
                end
            end else if (clear_pulse !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL lone_clear: clear_pulse=%b key_event=%b at edge %0d, want clear only with key_event", clear_pulse, key_event, pe);
            end
            prev_ke = key_event;
        end
    end

    // hold the key levels for n rising edges; returns at the falling edge after the last one
    task automatic drive(input logic op, input logic pl, input logic cl, input int n);
        in_op_cl = op;
        in_pl_pa = pl;
        in_clear = cl;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({open_state, play_state, clear_pulse, key_event, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b, want 00000", {open_state, play_state, clear_pulse, key_event, busy});
        end
        reset = 1'b0;
        mon_en = 1'b1;
        drive(0, 0, 0, 2);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_busy: got %b, want 0", busy);
        end
    endtask

    task automatic test_play();
        int base;
        base = pe;
        exp_play = 1'b1;
        exp_q.push_back('{base + 5, exp_open, exp_play, 1'b0});
        drive(0, 1, 0, 4);
        checks++;
        if (play_state !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL play_early: after edge 3 play=%b busy=%b, want play=0 busy=1", play_state, busy);
        end
        drive(0, 1, 0, 1);
        checks++;
        if (play_state !== 1'b1) begin
            failures++;
            $display("FAIL play_edge4: play=%b, want 1", play_state);
        end
        drive(0, 1, 0, 20);
        checks++;
        if (play_state !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL play_hold: play=%b busy=%b, want play=1 busy=1", play_state, busy);
        end
        drive(0, 0, 0, 6);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL play_release: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_glitch();
        drive(1, 0, 0, 3);
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 3);
        drive(0, 0, 0, 6);
        checks++;
        if (open_state !== exp_open || busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch: open=%b busy=%b, want open=%b busy=0", open_state, busy, exp_open);
        end
    endtask

    task automatic test_multi_hit();
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 1, 1);
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL multi_busy: cycle %0d busy=%b, want 0", i, busy);
            end
        end
        drive(0, 0, 0, 2);
    endtask

    task automatic test_rebounce();
        int base;
        base = pe;
        exp_open = ~exp_open;
        exp_q.push_back('{base + 5, exp_open, exp_play, 1'b0});
        drive(1, 0, 0, 6);
        drive(0, 0, 0, 2);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rebounce_rel_busy: busy=%b, want 1", busy);
        end
        drive(1, 0, 0, 8);
        checks++;
        if (open_state !== exp_open || busy !== 1'b1) begin
            failures++;
            $display("FAIL rebounce_held: open=%b busy=%b, want open=%b busy=1", open_state, busy, exp_open);
        end
        drive(0, 0, 0, 6);
        checks++;
        if (open_state !== exp_open || busy !== 1'b0) begin
            failures++;
            $display("FAIL rebounce_end: open=%b busy=%b, want open=%b busy=0", open_state, busy, exp_open);
        end
    endtask

    task automatic test_mid_reset();
        drive(0, 1, 0, 2);
        reset = 1'b1;
        drive(0, 1, 0, 1);
        exp_open = 1'b0;
        exp_play = 1'b0;
        checks++;
        if ({open_state, play_state, busy, key_event} !== 4'b0) begin
            failures++;
            $display("FAIL mid_reset: open,play,busy,event=%b, want 0000", {open_state, play_state, busy, key_event});
        end
        reset = 1'b0;
        drive(0, 0, 0, 6);
        checks++;
        if (play_state !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_after: play=%b busy=%b, want 0 0", play_state, busy);
        end
    endtask

    task automatic test_clear();
        int base;
        base = pe;
`ifdef CLEAR_LONGPRESS_EN
        exp_q.push_back('{base + 14, exp_open, exp_play, 1'b1});
`else
        exp_q.push_back('{base + 5, exp_open, exp_play, 1'b1});
`endif
        drive(0, 0, 1, 15);
        checks++;
        if (clear_pulse !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL clear_hold_end: clear=%b busy=%b, want clear=0 busy=1", clear_pulse, busy);
        end
        drive(0, 0, 0, 6);
        base = pe;
`ifndef CLEAR_LONGPRESS_EN
        exp_q.push_back('{base + 5, exp_open, exp_play, 1'b1});
`endif
        drive(0, 0, 1, 8);
        drive(0, 0, 0, 6);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clear_short: pending=%0d busy=%b, want pending=0 busy=0", exp_q.size(), busy);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = pe;
        exp_open = ~exp_open;
        exp_q.push_back('{base + 5, exp_open, exp_play, 1'b0});
        drive(1, 0, 0, 6);
        drive(0, 0, 0, 5);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: busy=%b, want 0", busy);
        end
        exp_play = ~exp_play;
        exp_q.push_back('{base + 16, exp_open, exp_play, 1'b0});
        drive(0, 1, 0, 6);
        drive(0, 0, 0, 6);
        checks++;
        if (open_state !== exp_open || play_state !== exp_play) begin
            failures++;
            $display("FAIL b2b_states: open=%b play=%b, want open=%b play=%b", open_state, play_state, exp_open, exp_play);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_play();
        test_glitch();
        test_multi_hit();
        test_rebounce();
        test_mid_reset();
        test_clear();
        test_back_to_back();
        drive(0, 0, 0, 4);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL final_queue: %0d expected commands still pending, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
